// File: rtl/pulse_trig_counter.sv
// pulse_trig_counter: a start pulse on en_i opens a counted high window on dout_o.
// Window length, repeat count and mode are latched when a start is accepted.
// Modes: 0 one-shot, 1 retriggerable, 2 periodic burst, 3 behaves like 0.
module pulse_trig_counter #(
  parameter int CNT_W = 8,
  parameter int REP_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic [REP_W-1:0] reps_i,
  output logic             dout_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   len_q, len_d;
  logic [REP_W-1:0]   repLeft_q, repLeft_d;
  logic [1:0]         mode_q, mode_d;
  logic               dout_q, dout_d;
  logic               done_q, done_d;

  logic               lastCycle;
  logic               startOk;

  assign lastCycle = (cnt_q == (len_q - CNT_W'(1)));
  assign startOk   = en_i && (len_i != '0);

  // Next-state logic: stop beats everything, then per-state window sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    repLeft_d = repLeft_q;
    mode_d    = mode_q;
    dout_d    = dout_q;
    done_d    = 1'b0;

    if (stop_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      dout_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d  = '0;
          dout_d = 1'b0;
          if (startOk) begin
            state_d   = RUN;
            len_d     = len_i;
            repLeft_d = reps_i;
            mode_d    = mode_i;
            dout_d    = 1'b1;
          end
        end
        RUN: begin
          if ((mode_q == 2'd1) && startOk) begin
            cnt_d  = '0;
            len_d  = len_i;
            dout_d = 1'b1;
          end else if (lastCycle) begin
            cnt_d  = '0;
            dout_d = 1'b0;
            if ((mode_q == 2'd2) && (repLeft_q != '0)) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (lastCycle) begin
            state_d   = RUN;
            cnt_d     = '0;
            dout_d    = 1'b1;
            repLeft_d = repLeft_q - REP_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          dout_d  = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      repLeft_q <= '0;
      mode_q    <= '0;
      dout_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      repLeft_q <= repLeft_d;
      mode_q    <= mode_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
    end
  end

  assign dout_o = dout_q;
  assign busy_o = (state_q != IDLE);
  assign done_o = done_q;
  assign cnt_o  = cnt_q;

endmodule

// File: tb/tb_pulse_trig_counter.sv
// tb_pulse_trig_counter: directed scoreboard bench for pulse_trig_counter.
// Each step drives inputs, queues the outputs expected after the next edge,
// then pops and compares them once that edge has passed.
module tb_pulse_trig_counter;

  logic       clk;
  logic       rstN;
  logic       en;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] len;
  logic [3:0] reps;
  logic       dout;
  logic       busy;
  logic       done;
  logic [7:0] cnt;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic       dout;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  pulse_trig_counter #(.CNT_W(8), .REP_W(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rstN),
    .en_i    (en),
    .stop_i  (stop),
    .mode_i  (mode),
    .len_i   (len),
    .reps_i  (reps),
    .dout_o  (dout),
    .busy_o  (busy),
    .done_o  (done),
    .cnt_o   (cnt)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, required completion");
    $fatal(1, "[TB] timeout");
  end

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic enVal, input logic stopVal,
                               input logic eDout, input logic eBusy, input logic eDone,
                               input logic [7:0] eCnt, input string tag);
    exp_t e;
    en   = enVal;
    stop = stopVal;
    e.dout = eDout;
    e.busy = eBusy;
    e.done = eDone;
    e.cnt  = eCnt;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      compare("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      compare({e.tag, "_dout"}, {31'd0, dout}, {31'd0, e.dout});
      compare({e.tag, "_busy"}, {31'd0, busy}, {31'd0, e.busy});
      compare({e.tag, "_done"}, {31'd0, done}, {31'd0, e.done});
      compare({e.tag, "_cnt"},  {24'd0, cnt},  {24'd0, e.cnt});
    end
  endtask

  task automatic step(input logic enVal, input logic stopVal,
                      input logic eDout, input logic eBusy, input logic eDone,
                      input logic [7:0] eCnt, input string tag);
    applyStimulus(enVal, stopVal, eDout, eBusy, eDone, eCnt, tag);
    checkOutput();
  endtask

  task automatic checkIdleNow(input string tag);
    compare({tag, "_dout"}, {31'd0, dout}, 32'd0);
    compare({tag, "_busy"}, {31'd0, busy}, 32'd0);
    compare({tag, "_done"}, {31'd0, done}, 32'd0);
    compare({tag, "_cnt"},  {24'd0, cnt},  32'd0);
  endtask

  // Directed sequence covering all modes, stop, len=0 and async reset.
  initial begin
    rstN = 1'b0;
    en   = 1'b0;
    stop = 1'b0;
    mode = 2'd0;
    len  = 8'd0;
    reps = 4'd0;
    repeat (10) @(posedge clk);
    #1;
    checkIdleNow("reset");
    rstN = 1'b1;

    // One-shot, len 5.
    mode = 2'd0; len = 8'd5;
    step(1, 0, 1, 1, 0, 8'd0, "oneshot_start");
    for (int i = 1; i < 5; i++) step(0, 0, 1, 1, 0, 8'(i), "oneshot_run");
    step(0, 0, 0, 0, 1, 8'd0, "oneshot_done");
    step(0, 0, 0, 0, 0, 8'd0, "oneshot_idle");

    // One-shot with a second en mid-window and len changed mid-window.
    step(1, 0, 1, 1, 0, 8'd0, "ignore_start");
    len = 8'd2;
    step(0, 0, 1, 1, 0, 8'd1, "ignore_run");
    step(1, 0, 1, 1, 0, 8'd2, "ignore_en");
    step(0, 0, 1, 1, 0, 8'd3, "ignore_run");
    step(0, 0, 1, 1, 0, 8'd4, "ignore_run");
    step(0, 0, 0, 0, 1, 8'd0, "ignore_done");
    step(0, 0, 0, 0, 0, 8'd0, "ignore_idle");

    // Retrigger at cnt 2 of a 4-cycle window gives 7 continuous high cycles.
    mode = 2'd1; len = 8'd4;
    step(1, 0, 1, 1, 0, 8'd0, "retrig_start");
    step(0, 0, 1, 1, 0, 8'd1, "retrig_run");
    step(0, 0, 1, 1, 0, 8'd2, "retrig_run");
    step(1, 0, 1, 1, 0, 8'd0, "retrig_restart");
    for (int i = 1; i < 4; i++) step(0, 0, 1, 1, 0, 8'(i), "retrig_run2");
    step(0, 0, 0, 0, 1, 8'd0, "retrig_done");
    step(0, 0, 0, 0, 0, 8'd0, "retrig_idle");

    // Retrigger on the final cycle wins over completion and relatches len.
    len = 8'd2;
    step(1, 0, 1, 1, 0, 8'd0, "retrig_last_start");
    step(0, 0, 1, 1, 0, 8'd1, "retrig_last_run");
    len = 8'd3;
    step(1, 0, 1, 1, 0, 8'd0, "retrig_last_restart");
    step(0, 0, 1, 1, 0, 8'd1, "retrig_last_run2");
    step(0, 0, 1, 1, 0, 8'd2, "retrig_last_run2");
    step(0, 0, 0, 0, 1, 8'd0, "retrig_last_done");

    // Periodic len 3, reps 2: 111000111000111 then done; en while busy ignored.
    step(0, 0, 0, 0, 0, 8'd0, "burst_idle");
    mode = 2'd2; len = 8'd3; reps = 4'd2;
    for (int w = 0; w < 5; w++) begin
      for (int c = 0; c < 3; c++) begin
        step((w == 0 && c == 0) || (w == 1 && c == 1) || (w == 2 && c == 0), 0,
             (w % 2 == 0), 1, 0, 8'(c), "burst");
      end
    end
    step(0, 0, 0, 0, 1, 8'd0, "burst_done");

    // Back-to-back start on the done cycle, with minimum length 1.
    mode = 2'd0; len = 8'd1; reps = 4'd0;
    step(1, 0, 1, 1, 0, 8'd0, "b2b_start");
    step(0, 0, 0, 0, 1, 8'd0, "b2b_done");
    step(0, 0, 0, 0, 0, 8'd0, "b2b_idle");

    // Periodic len 6 aborted at cnt 3, stop beats a simultaneous en.
    mode = 2'd2; len = 8'd6; reps = 4'd1;
    step(1, 0, 1, 1, 0, 8'd0, "stop_start");
    for (int i = 1; i < 4; i++) step(0, 0, 1, 1, 0, 8'(i), "stop_run");
    step(1, 1, 0, 0, 0, 8'd0, "stop_abort");
    step(0, 0, 0, 0, 0, 8'd0, "stop_idle");

    // len 0 start is ignored.
    mode = 2'd0; len = 8'd0;
    step(1, 0, 0, 0, 0, 8'd0, "len0_ignored");
    step(0, 0, 0, 0, 0, 8'd0, "len0_idle");

    // Async reset mid-window, then no resume until a fresh en.
    len = 8'd8;
    step(1, 0, 1, 1, 0, 8'd0, "areset_start");
    step(0, 0, 1, 1, 0, 8'd1, "areset_run");
    step(0, 0, 1, 1, 0, 8'd2, "areset_run");
    #2;
    rstN = 1'b0;
    #1;
    checkIdleNow("areset_async");
    @(posedge clk);
    #1;
    rstN = 1'b1;
    step(0, 0, 0, 0, 0, 8'd0, "areset_noresume");
    len = 8'd3;
    step(1, 0, 1, 1, 0, 8'd0, "areset_fresh");
    step(0, 0, 1, 1, 0, 8'd1, "areset_fresh");
    step(0, 0, 1, 1, 0, 8'd2, "areset_fresh");
    step(0, 0, 0, 0, 1, 8'd0, "areset_done");
    step(0, 0, 0, 0, 0, 8'd0, "areset_idle");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
